trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
Exception sequencing controller for the MIPS-lite core. Takes per-instruction trap information at the EX stage (trap_type from the SYSCALL/BREAK decoder, plus overflow, reserved-instruction and interrupt sources) and prioritises it into a single exception. It then updates the minimal CP0 state (EPC, Cause, Status.EXL), flushes the pipeline and redirects fetch through a valid/ready handshake. It also sequences ERET return.

Parameters:
HANDLER_ADDR, 32'h0000_0080, fetch target for every exception.
INT_W, 6, number of hardware interrupt lines.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX-stage instruction valid this cycle
ex_pc  input  32  PC of EX-stage instruction
ex_bd  input  1  EX instruction sits in a branch delay slot
trap_type  input  6  8=Sys, 9=Bp, 0=none; all other values ignored
ex_ov  input  1  arithmetic overflow on EX instruction
ex_ri  input  1  reserved instruction on EX instruction
ex_eret  input  1  EX instruction is ERET
int_pending  input  INT_W  level-sensitive interrupt lines
redirect_ready  input  1  fetch accepts redirect
flush  output  1  kill IF/ID/EX contents
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  32  redirect target
epc  output  32  CP0 EPC
cause  output  32  CP0 Cause: [31]=BD, [15:10]=IP, [6:2]=ExcCode, others 0
status_exl  output  1  CP0 Status.EXL
busy  output  1  FSM not in IDLE

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; flush, redirect_valid, status_exl, busy = 0; epc, cause, redirect_pc = 0. Assertion mid-sequence forces IDLE immediately and drops flush/redirect_valid asynchronously.
- cause[15:10] registers int_pending every cycle, independent of state.
- Event qualification occurs only in IDLE with ex_valid=1. In any other state ex_* inputs are ignored.
- Priority, highest first:
  - interrupt (|int_pending and status_exl=0), ExcCode 0
  - ex_ri, ExcCode 10
  - trap_type==8, ExcCode 8
  - trap_type==9, ExcCode 9
  - ex_ov, ExcCode 12
  - ex_eret (return, no exception)
- An exception on an ERET instruction wins over the ERET.
- Exception taken at cycle N, updated at the N+1 edge:
  - ExcCode written.
  - If status_exl was 0: epc = ex_bd ? ex_pc-4 : ex_pc (mod 2^32), cause[31] = ex_bd.
  - If status_exl was 1: epc and BD hold their values.
  - status_exl=1; redirect_pc=HANDLER_ADDR.
- ERET at cycle N: status_exl=0 at N+1; redirect_pc=epc.
- FSM states:
  - IDLE: on a qualified exception or ERET, go to FLUSH.
  - FLUSH: flush=1 for exactly one cycle, then REDIRECT.
  - REDIRECT: redirect_valid=1 and redirect_pc stable until redirect_valid&redirect_ready; next cycle IDLE.
  - Latency: event cycle N -> flush at N+1 -> redirect_valid from N+2. With redirect_ready tied high, IDLE is reached at N+3.
- busy=1 in FLUSH and REDIRECT.
- Interrupt arriving during FLUSH/REDIRECT is not taken until IDLE. Since EXL is then 1, it is deferred until after ERET.
- Unknown trap_type values (not 0/8/9) are treated as no trap.

Optional Feature:
TRAP_CTRL_STATS_EN: adds output trap_count[15:0]. The counter increments by one on each taken Sys or Bp exception (at the N+1 edge), saturates at 16'hFFFF and resets to 0. ERET, interrupts, RI and Ov do not count. Without the macro the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then ex_valid=1, ex_pc=32'h0000_1000, trap_type=8, redirect_ready=1.
   - N+1: epc=0x1000, cause[6:2]=8, status_exl=1, flush=1.
   - N+2: redirect_valid=1, redirect_pc=0x80.
   - N+3: IDLE.
2. trap_type=9, ex_bd=1, ex_pc=0x2004 -> epc=0x2000, cause[31]=1, ExcCode=9.
3. Same-cycle int_pending=6'b000001, ex_ri=1, trap_type=8 with status_exl=0 -> ExcCode=0, cause[10]=1.
   - Repeat with status_exl=1: ExcCode=10 and epc unchanged.
4. redirect_ready held 0 for 5 cycles in REDIRECT -> redirect_valid and redirect_pc=0x80 stay stable, ex_valid traps ignored; release -> IDLE one cycle after the handshake.
5. ERET with epc=0x1000, status_exl=1 -> flush at N+1, redirect_pc=0x1000, status_exl=0.
6. rst_n low during FLUSH -> flush=0 immediately, all outputs 0.
   - With TRAP_CTRL_STATS_EN: after 3 Sys traps plus 1 Ov, trap_count=3.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl -- exception sequencing controller for the MIPS-lite core.
//
// It prioritises the trap sources of the EX-stage instruction into one
// exception. It then updates the minimal CP0 state (EPC, Cause,
// Status.EXL), flushes the pipeline for one cycle and redirects fetch
// through a valid/ready handshake. ERET is sequenced the same way:
// EXL is cleared and fetch is redirected to EPC.
//
// Parameters:
//   HANDLER_ADDR  fetch target for every exception
//   INT_W         number of hardware interrupt lines
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   ex_valid         EX-stage instruction valid this cycle
//   ex_pc, ex_bd     PC of the EX instruction, branch-delay-slot flag
//   trap_type        8 = SYSCALL, 9 = BREAK, any other value = no trap
//   ex_ov, ex_ri     overflow / reserved-instruction on the EX instruction
//   ex_eret          EX instruction is ERET
//   int_pending      level-sensitive interrupt lines
//   redirect_ready   fetch accepts the redirect
//   flush            kill IF/ID/EX contents (one cycle)
//   redirect_valid   redirect request to fetch; redirect_pc is its target
//   epc, cause       CP0 EPC and Cause ([31]=BD, [15:10]=IP, [6:2]=ExcCode)
//   status_exl       CP0 Status.EXL
//   busy             sequencer is not idle
//
// Optional build macro TRAP_CTRL_STATS_EN adds the trap_count[15:0] output.
// It is a saturating count of taken SYSCALL/BREAK exceptions.

module trap_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int          INT_W        = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_bd,
  input  logic [5:0]       trap_type,
  input  logic             ex_ov,
  input  logic             ex_ri,
  input  logic             ex_eret,
  input  logic [INT_W-1:0] int_pending,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [31:0]      cause,
  output logic             status_exl,
  output logic             busy
`ifdef TRAP_CTRL_STATS_EN
  ,
  output logic [15:0]      trap_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  state_t      state, state_next;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  exc_code;
  logic [5:0]  ip_in;

  logic        take_int, is_sys, is_bp, exc_any;
  logic [4:0]  exc_code_sel;
  logic        evt_exc, evt_eret;

  // The Cause IP field is always 6 bits wide. Map the interrupt lines onto it.
  generate
    if (INT_W >= 6) begin : g_ip_trunc
      assign ip_in = int_pending[5:0];
    end else begin : g_ip_ext
      assign ip_in = {{(6 - INT_W){1'b0}}, int_pending};
    end
  endgenerate

  // Source decode and priority. An interrupt is masked while EXL is set.
  always_comb begin
    // NOTE: every signal written in a combinational block is given a default
    // first, so no path leaves it unassigned and no latch is inferred.
    exc_code_sel = EXC_OV;
    take_int     = (|int_pending) && !status_exl;
    is_sys       = (trap_type == 6'd8);
    is_bp        = (trap_type == 6'd9);
    exc_any      = take_int || ex_ri || is_sys || is_bp || ex_ov;

    if (take_int)    exc_code_sel = EXC_INT;
    else if (ex_ri)  exc_code_sel = EXC_RI;
    else if (is_sys) exc_code_sel = EXC_SYS;
    else if (is_bp)  exc_code_sel = EXC_BP;

    // Events are only qualified while idle. Any exception beats an ERET.
    evt_exc  = (state == S_IDLE) && ex_valid && exc_any;
    evt_eret = (state == S_IDLE) && ex_valid && ex_eret && !exc_any;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next     = state;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    busy           = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (evt_exc || evt_eret) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        flush      = 1'b1;
        state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The outputs are decoded from the state register. An asynchronous reset
  // therefore drops flush/redirect_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // CP0 state and the redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc         <= '0;
      cause_bd    <= 1'b0;
      cause_ip    <= '0;
      exc_code    <= '0;
      status_exl  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      cause_ip <= ip_in;
      if (evt_exc) begin
        exc_code    <= exc_code_sel;
        status_exl  <= 1'b1;
        redirect_pc <= HANDLER_ADDR;
        // A nested exception keeps the original EPC and BD.
        if (!status_exl) begin
          epc      <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
          cause_bd <= ex_bd;
        end
      end else if (evt_eret) begin
        status_exl  <= 1'b0;
        redirect_pc <= epc;
      end
    end
  end

  assign cause = {cause_bd, 15'd0, cause_ip, 3'd0, exc_code, 2'd0};

`ifdef TRAP_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_count <= '0;
    end else if (evt_exc && (exc_code_sel == EXC_SYS || exc_code_sel == EXC_BP)
                 && (trap_count != 16'hFFFF)) begin
      trap_count <= trap_count + 16'd1;
    end
  end
`endif

endmodule
